dcache_victim_ctrl: RTL

Miss-handling controller between the write-back data cache and the 4-entry FIFO victim cache. On a dcache miss it probes the victim cache. On a victim hit it returns that line. Otherwise it fetches the line from the memory interface. In either case it pushes the line the dcache is evicting into the victim cache, then hands the refill line back to the dcache with a one-cycle fill pulse.

---
 rtl/dcache_victim_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dcache_victim_ctrl.sv
// Miss handler between the write-back dcache and the 4-entry FIFO victim cache:
// probe the victim, fall back to memory, push the evicted line, then refill.
module dcache_victim_ctrl #(
    parameter int DCACHE_LINE_WIDTH = 128,
    parameter int DCACHE_TAG_BITS   = 20,
    parameter int STAT_W            = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req_i,
    input  logic [DCACHE_TAG_BITS-1:0]   miss_tag_i,
    input  logic                         evict_valid_i,
    input  logic [DCACHE_TAG_BITS-1:0]   evict_tag_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic [DCACHE_TAG_BITS-1:0]   v_tag_o,
    output logic                         v_wr_en_o,
    output logic [DCACHE_LINE_WIDTH-1:0] data_cache2victim_o,
    input  logic                         v_hit_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] data_victim2cache_i,
    output logic                         mem_req_o,
    output logic [DCACHE_TAG_BITS-1:0]   mem_tag_o,
    input  logic                         mem_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
    output logic                         fill_valid_o,
    output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
    output logic                         fill_src_o,
    output logic                         miss_ack_o,
    output logic                         busy_o,
    output logic [STAT_W-1:0]            vhit_cnt_o,
    output logic [STAT_W-1:0]            vmiss_cnt_o
);

    typedef enum logic [2:0] {IDLE, PROBE, MEM, EVICT, FILL} state_t;

    localparam logic [STAT_W-1:0] CNT_MAX = {STAT_W{1'b1}};

    state_t                         state, state_nxt, after_data;
    logic [DCACHE_TAG_BITS-1:0]     miss_tag_q, evict_tag_q;
    logic                           evict_valid_q;
    logic [DCACHE_LINE_WIDTH-1:0]   evict_data_q, line_q;
    logic                           src_q;
    logic [STAT_W-1:0]              vhit_cnt, vmiss_cnt;
    logic                           mem_req_raw;

    // Once the refill line is known, the eviction write (if any) precedes the fill.
    assign after_data = evict_valid_q ? EVICT : FILL;

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            miss_tag_q    <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
            line_q        <= '0;
            src_q         <= 1'b0;
            vhit_cnt      <= '0;
            vmiss_cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (miss_req_i) begin
                    miss_tag_q    <= miss_tag_i;
                    evict_valid_q <= evict_valid_i;
                    evict_tag_q   <= evict_tag_i;
                    evict_data_q  <= evict_data_i;
                end
                PROBE: if (v_hit_i) begin
                    line_q <= data_victim2cache_i;
                    src_q  <= 1'b1;
                    if (vhit_cnt != CNT_MAX) vhit_cnt <= vhit_cnt + 1'b1;
                end else begin
                    if (vmiss_cnt != CNT_MAX) vmiss_cnt <= vmiss_cnt + 1'b1;
                end
                MEM: if (mem_ack_i) begin
                    line_q <= mem_data_i;
                    src_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        state_nxt           = state;
        v_tag_o             = '0;
        v_wr_en_o           = 1'b0;
        data_cache2victim_o = '0;
        mem_req_raw         = 1'b0;
        mem_tag_o           = '0;
        fill_valid_o        = 1'b0;
        fill_data_o         = '0;
        fill_src_o          = 1'b0;
        miss_ack_o          = 1'b0;
        case (state)
            IDLE:  if (miss_req_i) state_nxt = PROBE;
            PROBE: begin
                v_tag_o   = miss_tag_q;
                state_nxt = v_hit_i ? after_data : MEM;
            end
            MEM: begin
                mem_req_raw = 1'b1;
                mem_tag_o   = miss_tag_q;
                if (mem_ack_i) state_nxt = after_data;
            end
            EVICT: begin
                v_wr_en_o           = 1'b1;
                v_tag_o             = evict_tag_q;
                data_cache2victim_o = evict_data_q;
                state_nxt           = FILL;
            end
            FILL: begin
                fill_valid_o = 1'b1;
                miss_ack_o   = 1'b1;
                fill_data_o  = line_q;
                fill_src_o   = src_q;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An outstanding memory request is withdrawn as soon as reset is asserted.
    assign mem_req_o   = mem_req_raw & ~rst;
    assign busy_o      = (state != IDLE);
    assign vhit_cnt_o  = vhit_cnt;
    assign vmiss_cnt_o = vmiss_cnt;

endmodule
